ibex_lsu_resp: RTL and testbench
================================

Name: ibex_lsu_resp

Overview:
- Load/store response assembler: the producing end of the LSU-to-writeback interface (rf_*_lsu, lsu_resp_valid/err).
- Accepts a transfer descriptor from the LSU request FSM, then collects 1 or 2 data-bus response beats: misaligned integer accesses and 64-bit+tag capability accesses.
- Extracts, aligns and sign-extends integer load data, and assembles memory-format capabilities.
- Presents one completed response to the writeback stage in the cycle of the final beat.

Parameters:
- ResetAll, 1'b0, also reset the descriptor/beat-0 datapath flops (control flops are always reset)
- CheriCapWidth, 91, register-format capability width
- CheriNullCap, 91'h0, value driven on rf_wdata_cap_lsu_o when not writing a capability

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  descriptor valid; pulse in the cycle the first bus request is granted
- start_is_store_i  in  1  transfer is a store (no RF write)
- start_is_cap_i  in  1  capability transfer (always 2 beats)
- start_split_i  in  1  misaligned integer transfer (2 beats)
- start_type_i  in  2  2'b00 word, 2'b01 half, 2'b1x byte
- start_sign_ext_i  in  1  sign-extend half/byte loads
- start_offset_i  in  2  byte offset addr[1:0]
- start_tag_clr_i  in  1  authorising cap lacks load-cap permission; clear loaded tag
- busy_o  out  1  transfer outstanding; request side must not assert start_i unless final beat is present
- data_rvalid_i  in  1  bus response beat valid
- data_rdata_i  in  32  response data
- data_rtag_i  in  1  response tag bit
- data_err_i  in  1  response error
- mem_cap_o  out  65  {tag, hi word, lo word} for external decompressor
- mem_cap_expanded_i  in  CheriCapWidth  register-format cap decoded from mem_cap_o (combinational)
- rf_wdata_int_lsu_o  out  32  integer load data
- rf_wdata_cap_lsu_o  out  CheriCapWidth  capability load data
- rf_we_lsu_o  out  1  RF write
- rf_wcap_lsu_o  out  1  write is capability
- lsu_resp_valid_o  out  1  transfer complete
- lsu_resp_err_o  out  1  transfer completed with bus error

Behaviour:
- Clock/reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
- States: IDLE, WAIT_LAST (1-beat transfer or 2nd beat), WAIT_FIRST (1st of 2 beats).
- start_i in IDLE:
  - to WAIT_FIRST if is_cap or split, else to WAIT_LAST;
  - descriptor captured.
- WAIT_FIRST:
  - on rvalid, capture rdata/rtag into beat-0 flops;
  - capture err into sticky err_q;
  - go to WAIT_LAST.
- WAIT_LAST:
  - rvalid is the final beat; outputs valid this cycle (combinational from bus, zero added latency);
  - next state IDLE, or the new transfer's state if start_i is also high (back-to-back allowed, counts as same-cycle completion).
- busy_o = (state != IDLE) & ~(state==WAIT_LAST & data_rvalid_i).
- Outputs are zero/CheriNullCap whenever no final beat is present, including during and after reset.
- Final-beat outputs:
  - lsu_resp_valid_o = 1;
  - lsu_resp_err_o = err_q | data_err_i;
  - rf_we_lsu_o = ~is_store & ~lsu_resp_err_o;
  - rf_wcap_lsu_o = rf_we_lsu_o & is_cap.
- Integer extraction:
  - raw64 = split ? {rdata_final, beat0} : {32'h0, rdata_final};
  - sh = raw64 >> (offset*8), low 32 bits used;
  - word: sh;
  - half: sh[15:0], zero- or sign-extended per sign_ext;
  - byte: sh[7:0], likewise.
- Capability:
  - mem_cap_o = {beat0_tag & rtag_final & ~tag_clr, rdata_final, beat0};
  - rf_wdata_cap_lsu_o = rf_wcap_lsu_o ? mem_cap_expanded_i : CheriNullCap;
  - rf_wdata_int_lsu_o = 0 for cap loads.
- Errors: an error on beat 0 is sticky; the second beat is still awaited; one response with err, no write.
- Stores: identical beat counting; only lsu_resp_valid/err asserted.
- Illegal conditions (assertions, behaviour ignored):
  - rvalid in IDLE;
  - start_i while busy_o;
  - cap with offset != 0;
  - split with word offset 0 or half offset != 3.
- err_q cleared on start_i. Descriptor flops are enabled only on start_i.
- Reset mid-transfer: immediate return to IDLE, err_q cleared, in-flight beats dropped.

Test Plan:
- Word load, offset 0: rdata 32'hDEADBEEF -> same cycle resp_valid=1, we=1, wcap=0, int=32'hDEADBEEF; busy_o low in that cycle.
- Byte load, sign_ext, offset 2, rdata 32'h0080_0000 -> int 32'hFFFF_FF80; same with sign_ext=0 -> 32'h0000_0080.
- Split word load, offset 1: beats 32'h44332211 then 32'h88776655 -> single resp on beat 2, int 32'h55443322; no resp on beat 1.
- Cap load: beats lo 32'h1111_1111 tag 1, hi 32'h2222_2222 tag 1 -> mem_cap_o = {1'b1, 32'h22222222, 32'h11111111}, wcap=1; repeat with tag_clr=1 -> tag bit 0.
- Cap load with err on beat 0 only -> one resp on beat 2 with err=1, we=0, cap data = CheriNullCap; next start_i coincident with the final beat accepted with no idle cycle.
- Assert rst_ni low while in WAIT_FIRST -> all outputs 0, busy_o=0; a later rvalid is ignored (no resp).

Source files
------------

// File: rtl/ibex_lsu_resp.sv
// Load/store response assembler: collects one or two data-bus beats per
// transfer, aligns/sign-extends integer load data, builds memory-format
// capabilities and presents a single completed response to writeback.
module ibex_lsu_resp #(
  parameter bit                       ResetAll      = 1'b0,
  parameter int unsigned              CheriCapWidth = 91,
  parameter logic [CheriCapWidth-1:0] CheriNullCap  = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     start_is_store_i,
  input  logic                     start_is_cap_i,
  input  logic                     start_split_i,
  input  logic [1:0]               start_type_i,
  input  logic                     start_sign_ext_i,
  input  logic [1:0]               start_offset_i,
  input  logic                     start_tag_clr_i,
  output logic                     busy_o,
  input  logic                     data_rvalid_i,
  input  logic [31:0]              data_rdata_i,
  input  logic                     data_rtag_i,
  input  logic                     data_err_i,
  output logic [64:0]              mem_cap_o,
  input  logic [CheriCapWidth-1:0] mem_cap_expanded_i,
  output logic [31:0]              rf_wdata_int_lsu_o,
  output logic [CheriCapWidth-1:0] rf_wdata_cap_lsu_o,
  output logic                     rf_we_lsu_o,
  output logic                     rf_wcap_lsu_o,
  output logic                     lsu_resp_valid_o,
  output logic                     lsu_resp_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    WAIT_LAST
  } state_e;

  typedef struct packed {
    logic       is_store;
    logic       is_cap;
    logic       split;
    logic [1:0] typ;
    logic       sign_ext;
    logic [1:0] offset;
    logic       tag_clr;
  } desc_t;

  state_e      state_q, start_state;
  logic        err_q;
  desc_t       desc_d, desc_q;
  logic [31:0] rdata0_d, rdata0_q;
  logic        rtag0_d, rtag0_q;

  logic        final_beat;
  logic        beat0;
  logic [63:0] raw64;
  logic [5:0]  shamt;
  logic [31:0] sh;
  logic [31:0] ext;

  assign final_beat  = (state_q == WAIT_LAST) & data_rvalid_i;
  assign beat0       = (state_q == WAIT_FIRST) & data_rvalid_i;
  assign start_state = (start_is_cap_i | start_split_i) ? WAIT_FIRST : WAIT_LAST;

  // Next values for the descriptor (loaded on start_i) and beat-0 flops
  always_comb begin
    desc_d   = desc_q;
    rdata0_d = rdata0_q;
    rtag0_d  = rtag0_q;
    if (start_i) begin
      desc_d = '{is_store: start_is_store_i, is_cap: start_is_cap_i,
                 split: start_split_i, typ: start_type_i,
                 sign_ext: start_sign_ext_i, offset: start_offset_i,
                 tag_clr: start_tag_clr_i};
    end
    if (beat0) begin
      rdata0_d = data_rdata_i;
      rtag0_d  = data_rtag_i;
    end
  end

  // Datapath flops carry a reset only when ResetAll is set
  if (ResetAll) begin : g_dp_rst
    // Descriptor and beat-0 storage with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        desc_q   <= '0;
        rdata0_q <= '0;
        rtag0_q  <= 1'b0;
      end else begin
        desc_q   <= desc_d;
        rdata0_q <= rdata0_d;
        rtag0_q  <= rtag0_d;
      end
    end
  end else begin : g_dp_nrst
    // Descriptor and beat-0 storage without reset
    always_ff @(posedge clk_i) begin
      desc_q   <= desc_d;
      rdata0_q <= rdata0_d;
      rtag0_q  <= rtag0_d;
    end
  end

  // Beat-counting FSM and sticky beat-0 error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      if (start_i) begin
        err_q <= 1'b0;
      end else if (beat0 & data_err_i) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE:       if (start_i) state_q <= start_state;
        WAIT_FIRST: if (data_rvalid_i) state_q <= WAIT_LAST;
        WAIT_LAST:  if (data_rvalid_i) state_q <= start_i ? start_state : IDLE;
        default:    state_q <= IDLE;
      endcase
    end
  end

  // Response outputs, combinational from the final bus beat
  always_comb begin
    busy_o           = (state_q != IDLE) & ~final_beat;
    lsu_resp_valid_o = final_beat;
    lsu_resp_err_o   = final_beat & (err_q | data_err_i);
    rf_we_lsu_o      = final_beat & ~desc_q.is_store & ~lsu_resp_err_o;
    rf_wcap_lsu_o    = rf_we_lsu_o & desc_q.is_cap;

    raw64 = desc_q.split ? {data_rdata_i, rdata0_q} : {32'h0, data_rdata_i};
    shamt = {1'b0, desc_q.offset, 3'b000};
    sh    = raw64[shamt +: 32];
    case (desc_q.typ)
      2'b00:   ext = sh;
      2'b01:   ext = {{16{desc_q.sign_ext & sh[15]}}, sh[15:0]};
      default: ext = {{24{desc_q.sign_ext & sh[7]}}, sh[7:0]};
    endcase
    rf_wdata_int_lsu_o = (rf_we_lsu_o & ~desc_q.is_cap) ? ext : '0;

    mem_cap_o = final_beat
              ? {rtag0_q & data_rtag_i & ~desc_q.tag_clr, data_rdata_i, rdata0_q}
              : '0;
    rf_wdata_cap_lsu_o = rf_wcap_lsu_o ? mem_cap_expanded_i : CheriNullCap;
  end

  a_no_rvalid_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == IDLE) |-> !data_rvalid_i);
  a_no_start_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    start_i |-> !busy_o);
  a_cap_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (start_i && start_is_cap_i) |-> (start_offset_i == 2'b00));
  a_split_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (start_i && start_split_i && !start_is_cap_i) |->
      ((start_type_i == 2'b00 && start_offset_i != 2'b00) ||
       (start_type_i == 2'b01 && start_offset_i == 2'b11)));

endmodule

// File: tb/tb_ibex_lsu_resp.sv
// Scoreboard bench for ibex_lsu_resp: the driver pushes the expected response
// when a transfer starts; a monitor compares whenever a response is presented.
module tb_ibex_lsu_resp;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        start_is_store_i = 1'b0;
  logic        start_is_cap_i = 1'b0;
  logic        start_split_i = 1'b0;
  logic [1:0]  start_type_i = '0;
  logic        start_sign_ext_i = 1'b0;
  logic [1:0]  start_offset_i = '0;
  logic        start_tag_clr_i = 1'b0;
  logic        busy_o;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic        data_rtag_i = 1'b0;
  logic        data_err_i = 1'b0;
  logic [64:0] mem_cap_o;
  logic [90:0] mem_cap_expanded_i;
  logic [31:0] rf_wdata_int_lsu_o;
  logic [90:0] rf_wdata_cap_lsu_o;
  logic        rf_we_lsu_o;
  logic        rf_wcap_lsu_o;
  logic        lsu_resp_valid_o;
  logic        lsu_resp_err_o;

  ibex_lsu_resp #(
    .ResetAll(1'b0),
    .CheriCapWidth(91),
    .CheriNullCap(91'h0)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .start_is_store_i(start_is_store_i), .start_is_cap_i(start_is_cap_i),
    .start_split_i(start_split_i), .start_type_i(start_type_i),
    .start_sign_ext_i(start_sign_ext_i), .start_offset_i(start_offset_i),
    .start_tag_clr_i(start_tag_clr_i), .busy_o(busy_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .data_rtag_i(data_rtag_i), .data_err_i(data_err_i),
    .mem_cap_o(mem_cap_o), .mem_cap_expanded_i(mem_cap_expanded_i),
    .rf_wdata_int_lsu_o(rf_wdata_int_lsu_o), .rf_wdata_cap_lsu_o(rf_wdata_cap_lsu_o),
    .rf_we_lsu_o(rf_we_lsu_o), .rf_wcap_lsu_o(rf_wcap_lsu_o),
    .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_resp_err_o(lsu_resp_err_o)
  );

  // Stand-in decompressor: any fixed, distinguishable function of mem_cap_o
  assign mem_cap_expanded_i = {~mem_cap_o[25:0], mem_cap_o};

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    bit        store, cap, split;
    bit [1:0]  typ;
    bit        sext;
    bit [1:0]  off;
    bit        clr;
    bit [31:0] d0, d1;   // d1 is always the final beat
    bit        t0, t1, e0, e1;
  } txn_t;

  typedef struct packed {
    bit        err, we, wcap;
    bit [31:0] ival;
    bit [64:0] mcap;
    bit        chk_mcap;
    bit [90:0] capv;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  bit        pend = 1'b0;
  bit [31:0] pd;
  bit        pt, pe;

  function automatic void chk(string n, logic [255:0] a, logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endfunction

  // Reference model: byte-addressed view of the fetched words
  function automatic exp_t model(txn_t t);
    exp_t        e;
    bit          two;
    bit [63:0]   img;
    bit [7:0]    mem [8];
    int unsigned size;
    bit [31:0]   v;
    two   = t.cap || t.split;
    e.err = (two && t.e0) || t.e1;
    e.we  = !t.store && !e.err;
    e.wcap = e.we && t.cap;
    img = two ? {t.d1, t.d0} : {32'h0, t.d1};
    for (int i = 0; i < 8; i++) mem[i] = img[8*i +: 8];
    size = (t.typ == 2'b00) ? 4 : (t.typ == 2'b01) ? 2 : 1;
    v = '0;
    for (int unsigned i = 0; i < size; i++) v[8*i +: 8] = mem[t.off + i];
    if (t.sext && size < 4 && v[8*size-1])
      for (int unsigned i = 8*size; i < 32; i++) v[i] = 1'b1;
    e.ival     = (e.we && !t.cap) ? v : 32'h0;
    e.mcap     = {t.t0 & t.t1 & ~t.clr, t.d1, t.d0};
    e.chk_mcap = t.cap;
    e.capv     = e.wcap ? {~e.mcap[25:0], e.mcap} : 91'h0;
    return e;
  endfunction

  function automatic txn_t mk(bit store, bit cap, bit split, bit [1:0] typ, bit sext,
                              bit [1:0] off, bit clr, bit [31:0] d0, bit [31:0] d1,
                              bit t0, bit t1, bit e0, bit e1);
    txn_t t;
    t = '{store: store, cap: cap, split: split, typ: typ, sext: sext, off: off,
          clr: clr, d0: d0, d1: d1, t0: t0, t1: t1, e0: e0, e1: e1};
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t        t;
    int unsigned k;
    k = $urandom_range(0, 5);
    t = mk($urandom_range(0, 3) == 0, 1'b0, 1'b0, 2'b00, 1'($urandom), 2'b00,
           1'($urandom), $urandom, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    case (k)
      0: ;
      1: begin t.typ = 2'b01; t.off = {1'($urandom), 1'b0}; end
      2: begin t.typ = {1'b1, 1'($urandom)}; t.off = 2'($urandom); end
      3: begin t.split = 1'b1; t.off = 2'($urandom_range(1, 3)); end
      4: begin t.split = 1'b1; t.typ = 2'b01; t.off = 2'b11; end
      default: begin t.cap = 1'b1; t.sext = 1'b0; end
    endcase
    return t;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
    start_i       = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = $urandom;
    data_rtag_i   = 1'($urandom);
    data_err_i    = 1'($urandom);
  endtask

  task automatic gaps();
    int unsigned n;
    n = $urandom_range(0, 2);
    for (int unsigned i = 0; i < n; i++) begin
      #1 chk("busy_wait", busy_o, 1);
      step();
    end
  endtask

  task automatic beat(bit [31:0] d, bit tg, bit er);
    data_rvalid_i = 1'b1;
    data_rdata_i  = d;
    data_rtag_i   = tg;
    data_err_i    = er;
  endtask

  task automatic do_txn(input txn_t t, input bit leave_open);
    bit two;
    two = t.cap || t.split;
    start_i          = 1'b1;
    start_is_store_i = t.store;
    start_is_cap_i   = t.cap;
    start_split_i    = t.split;
    start_type_i     = t.typ;
    start_sign_ext_i = t.sext;
    start_offset_i   = t.off;
    start_tag_clr_i  = t.clr;
    if (pend) begin
      beat(pd, pt, pe);
      pend = 1'b0;
    end
    sb.push_back(model(t));
    #1 chk("busy_start", busy_o, 0);
    step();
    gaps();
    if (two) begin
      beat(t.d0, t.t0, t.e0);
      #1 chk("busy_beat0", busy_o, 1);
      step();
      gaps();
    end
    if (leave_open) begin
      pend = 1'b1; pd = t.d1; pt = t.t1; pe = t.e1;
    end else begin
      beat(t.d1, t.t1, t.e1);
      #1 chk("busy_final", busy_o, 0);
      step();
    end
  endtask

  // Monitor: compare every presented response against the scoreboard
  always @(negedge clk_i) begin
    if (lsu_resp_valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=valid expected=none");
      end else begin
        mon_e = sb.pop_front();
        chk("resp_err", lsu_resp_err_o, mon_e.err);
        chk("resp_we", rf_we_lsu_o, mon_e.we);
        chk("resp_wcap", rf_wcap_lsu_o, mon_e.wcap);
        chk("resp_int", rf_wdata_int_lsu_o, mon_e.ival);
        chk("resp_cap", rf_wdata_cap_lsu_o, mon_e.capv);
        if (mon_e.chk_mcap) chk("resp_memcap", mem_cap_o, mon_e.mcap);
      end
    end else begin
      chk("idle_ctl", {lsu_resp_err_o, rf_we_lsu_o, rf_wcap_lsu_o}, 0);
      chk("idle_int", rf_wdata_int_lsu_o, 0);
      chk("idle_cap", rf_wdata_cap_lsu_o, 0);
      chk("idle_memcap", mem_cap_o, 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) step();
    chk("busy_reset", busy_o, 0);
    rst_ni = 1'b1;
    step();

    do_txn(mk(0, 0, 0, 2'b00, 0, 2'd0, 0, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0), 0);
    do_txn(mk(0, 0, 0, 2'b10, 1, 2'd2, 0, 32'h0, 32'h0080_0000, 0, 0, 0, 0), 0);
    do_txn(mk(0, 0, 0, 2'b10, 0, 2'd2, 0, 32'h0, 32'h0080_0000, 0, 0, 0, 0), 0);
    do_txn(mk(0, 0, 1, 2'b00, 0, 2'd1, 0, 32'h44332211, 32'h88776655, 0, 0, 0, 0), 0);
    do_txn(mk(0, 0, 1, 2'b01, 1, 2'd3, 0, 32'h80AABBCC, 32'h123456FF, 0, 0, 0, 0), 0);
    do_txn(mk(0, 1, 0, 2'b00, 0, 2'd0, 0, 32'h11111111, 32'h22222222, 1, 1, 0, 0), 0);
    do_txn(mk(0, 1, 0, 2'b00, 0, 2'd0, 1, 32'h11111111, 32'h22222222, 1, 1, 0, 0), 0);
    do_txn(mk(0, 1, 0, 2'b00, 0, 2'd0, 0, 32'h11111111, 32'h22222222, 1, 1, 1, 0), 1);
    do_txn(mk(0, 0, 0, 2'b00, 0, 2'd0, 0, 32'h0, 32'hCAFEF00D, 0, 0, 0, 0), 0);
    do_txn(mk(1, 0, 0, 2'b00, 0, 2'd0, 0, 32'h0, 32'h12345678, 0, 0, 0, 0), 0);
    do_txn(mk(0, 0, 0, 2'b01, 0, 2'd2, 0, 32'h0, 32'hBEEF0000, 0, 0, 0, 1), 0);

    // Reset while waiting for the first beat of a capability load
    start_i = 1'b1; start_is_cap_i = 1'b1; start_split_i = 1'b0;
    start_offset_i = 2'd0; start_is_store_i = 1'b0;
    step();
    #1 chk("busy_wait_first", busy_o, 1);
    rst_ni = 1'b0;
    #1 chk("busy_in_reset", busy_o, 0);
    beat(32'h55555555, 1'b1, 1'b0);
    step();
    step();
    rst_ni = 1'b1;
    step();
    chk("busy_after_reset", busy_o, 0);
    step();

    for (int n = 0; n < 300; n++)
      do_txn(rand_txn(), (n != 299) && ($urandom_range(0, 2) == 0));

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
